// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline control logic.
//   ctrl_state_e : hazard-controller FSM states
//   OP_LOAD/OP_STORE : RV32 major opcodes for memory instructions
//   REG_IDX_W : architectural register index width
package pipe_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/forward_unit.sv
// MW -> DE operand forwarding select generation (purely combinational).
// Ports:
//   rs1_de, rs2_de : source register indices of the DE/EX instruction
//   rd_mw          : destination register index of the MW instruction
//   reg_wr_mw      : MW instruction writes the register file
//   stall_mw       : MW register is held (writeback value not yet valid)
//   for_a, for_b   : select MW writeback value for operand A / B
module forward_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs1_de,
    input  logic [REG_IDX_W-1:0] rs2_de,
    input  logic [REG_IDX_W-1:0] rd_mw,
    input  logic                 reg_wr_mw,
    input  logic                 stall_mw,
    output logic                 for_a,
    output logic                 for_b
);

    logic fwd_ok;

    // x0 is never forwarded; load data is not valid while MW is stalled.
    assign fwd_ok = reg_wr_mw & (rd_mw != '0) & ~stall_mw;
    assign for_a  = fwd_ok & (rd_mw == rs1_de);
    assign for_b  = fwd_ok & (rd_mw == rs2_de);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall / flush / forwarding controller for the 3-stage RV32I pipeline.
// Sequences multi-cycle data-memory accesses with a bounded wait and issues
// flushes for taken branches, traps and memory timeouts.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   rs1_DE, rs2_DE, rd_MW : register indices for forwarding compare
//   reg_wrMW              : MW instruction writes the register file
//   mem_rdMW, mem_wrMW    : MW instruction is a load / store
//   dmem_ready            : data memory completes the MW access this cycle
//   br_taken, trap_taken  : branch redirect from DE/EX, trap redirect from CSR
//   Stall_IF, Stall_MW    : hold PC + IF/DE, hold MW register
//   Flush_DE, Flush_MW    : squash IF/DE, clear MW controls
//   For_A, For_B          : operand forwarding selects
//   mem_timeout           : one-cycle pulse for an abandoned memory access
// MEM_TIMEOUT must lie in 1..255 and 2**CNT_W must exceed it.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1_DE,
    input  logic [REG_IDX_W-1:0] rs2_DE,
    input  logic [REG_IDX_W-1:0] rd_MW,
    input  logic                 reg_wrMW,
    input  logic                 mem_rdMW,
    input  logic                 mem_wrMW,
    input  logic                 dmem_ready,
    input  logic                 br_taken,
    input  logic                 trap_taken,
    output logic                 Stall_IF,
    output logic                 Stall_MW,
    output logic                 Flush_DE,
    output logic                 Flush_MW,
    output logic                 For_A,
    output logic                 For_B,
    output logic                 mem_timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;

    logic mem_pend;
    logic stall;
    logic in_flush;

    assign mem_pend = (mem_rdMW | mem_wrMW) & ~dmem_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    // Next-state logic. The counter and timeout cause only survive while
    // waiting / flushing; every other path clears them.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        to_d    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (trap_taken) begin
                    state_d = FLUSH;
                end else if (mem_pend) begin
                    state_d = MEM_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            MEM_WAIT: begin
                if (trap_taken) begin
                    state_d = FLUSH;
                end else if (dmem_ready) begin
                    state_d = RUN;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = FLUSH;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            FLUSH: begin
                // Single-cycle squash; a trap arriving now is ignored.
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Output logic. Trap/timeout flush outranks the memory stall, which in
    // turn holds off a branch flush until the pipeline is released.
    always_comb begin
        in_flush    = (state_q == FLUSH);
        stall       = mem_pend & ~trap_taken & ~in_flush;
        Stall_IF    = stall;
        Stall_MW    = stall;
        Flush_MW    = in_flush | trap_taken;
        Flush_DE    = in_flush | trap_taken | (br_taken & ~stall);
        mem_timeout = in_flush & to_q;
    end

    forward_unit u_forward_unit (
        .rs1_de    (rs1_DE),
        .rs2_de    (rs2_DE),
        .rd_mw     (rd_MW),
        .reg_wr_mw (reg_wrMW),
        .stall_mw  (stall),
        .for_a     (For_A),
        .for_b     (For_B)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (MEM_TIMEOUT = 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 1 unit later, well before the next edge.
// Observed vector layout: {Stall_IF, Stall_MW, Flush_DE, Flush_MW, For_A, For_B, mem_timeout}
// Control stimulus layout: {mem_rdMW, mem_wrMW, dmem_ready, br_taken, trap_taken, rst}
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_DE, rs2_DE, rd_MW;
    logic       reg_wrMW, mem_rdMW, mem_wrMW, dmem_ready, br_taken, trap_taken;
    logic       Stall_IF, Stall_MW, Flush_DE, Flush_MW, For_A, For_B, mem_timeout;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_DE      (rs1_DE),
        .rs2_DE      (rs2_DE),
        .rd_MW       (rd_MW),
        .reg_wrMW    (reg_wrMW),
        .mem_rdMW    (mem_rdMW),
        .mem_wrMW    (mem_wrMW),
        .dmem_ready  (dmem_ready),
        .br_taken    (br_taken),
        .trap_taken  (trap_taken),
        .Stall_IF    (Stall_IF),
        .Stall_MW    (Stall_MW),
        .Flush_DE    (Flush_DE),
        .Flush_MW    (Flush_MW),
        .For_A       (For_A),
        .For_B       (For_B),
        .mem_timeout (mem_timeout)
    );

    task automatic test_reset();
        logic [6:0] obs;
        {mem_rdMW, mem_wrMW, dmem_ready, br_taken, trap_taken} = '0;
        {reg_wrMW, rd_MW, rs1_DE, rs2_DE} = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            obs = {Stall_IF, Stall_MW, Flush_DE, Flush_MW, For_A, For_B, mem_timeout};
            vectors++;
            if (obs !== 7'b0000000) begin
                $display("FAIL reset[%0d]: got %b expected %b", i, obs, 7'b0000000);
                miscompares++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_forward();
        logic [6:0]  obs;
        logic [15:0] regs [6] = '{
            {1'b1, 5'd5,  5'd5,  5'd7},
            {1'b1, 5'd5,  5'd7,  5'd5},
            {1'b0, 5'd5,  5'd5,  5'd5},
            {1'b1, 5'd0,  5'd0,  5'd0},
            {1'b1, 5'd31, 5'd31, 5'd31},
            {1'b1, 5'd5,  5'd4,  5'd6}
        };
        logic [6:0] expv [6] = '{
            7'b0000100, 7'b0000010, 7'b0000000,
            7'b0000000, 7'b0000110, 7'b0000000
        };
        {mem_rdMW, mem_wrMW, dmem_ready, br_taken, trap_taken, rst} = '0;
        for (int i = 0; i < 6; i++) begin
            {reg_wrMW, rd_MW, rs1_DE, rs2_DE} = regs[i];
            #1;
            obs = {Stall_IF, Stall_MW, Flush_DE, Flush_MW, For_A, For_B, mem_timeout};
            vectors++;
            if (obs !== expv[i]) begin
                $display("FAIL forward[%0d]: got %b expected %b", i, obs, expv[i]);
                miscompares++;
            end
            @(posedge clk); #1;
        end
    endtask

    // Load with 3 wait cycles; forwarding of r5 masked until ready.
    task automatic test_load_3cyc();
        logic [6:0] obs;
        logic [5:0] stim [5] = '{6'b100000, 6'b100000, 6'b100000, 6'b101000, 6'b000000};
        logic [6:0] expv [5] = '{7'b1100000, 7'b1100000, 7'b1100000, 7'b0000100, 7'b0000100};
        {reg_wrMW, rd_MW, rs1_DE, rs2_DE} = {1'b1, 5'd5, 5'd5, 5'd0};
        for (int i = 0; i < 5; i++) begin
            {mem_rdMW, mem_wrMW, dmem_ready, br_taken, trap_taken, rst} = stim[i];
            #1;
            obs = {Stall_IF, Stall_MW, Flush_DE, Flush_MW, For_A, For_B, mem_timeout};
            vectors++;
            if (obs !== expv[i]) begin
                $display("FAIL load_3cyc[%0d]: got %b expected %b", i, obs, expv[i]);
                miscompares++;
            end
            @(posedge clk); #1;
        end
    endtask

    // Store never completes: 5 stall cycles, then one timeout flush cycle.
    task automatic test_timeout();
        logic [6:0] obs;
        logic [5:0] stim [8] = '{6'b010000, 6'b010000, 6'b010000, 6'b010000,
                                 6'b010000, 6'b010000, 6'b000000, 6'b000000};
        logic [6:0] expv [8] = '{7'b1100000, 7'b1100000, 7'b1100000, 7'b1100000,
                                 7'b1100000, 7'b0011001, 7'b0000000, 7'b0000000};
        {reg_wrMW, rd_MW, rs1_DE, rs2_DE} = '0;
        for (int i = 0; i < 8; i++) begin
            {mem_rdMW, mem_wrMW, dmem_ready, br_taken, trap_taken, rst} = stim[i];
            #1;
            obs = {Stall_IF, Stall_MW, Flush_DE, Flush_MW, For_A, For_B, mem_timeout};
            vectors++;
            if (obs !== expv[i]) begin
                $display("FAIL timeout[%0d]: got %b expected %b", i, obs, expv[i]);
                miscompares++;
            end
            @(posedge clk); #1;
        end
    endtask

    // Branch resolved under a 2-cycle stall flushes DE only on release.
    task automatic test_branch_stall();
        logic [6:0] obs;
        logic [5:0] stim [4] = '{6'b100100, 6'b100100, 6'b101100, 6'b000000};
        logic [6:0] expv [4] = '{7'b1100000, 7'b1100000, 7'b0010000, 7'b0000000};
        {reg_wrMW, rd_MW, rs1_DE, rs2_DE} = '0;
        for (int i = 0; i < 4; i++) begin
            {mem_rdMW, mem_wrMW, dmem_ready, br_taken, trap_taken, rst} = stim[i];
            #1;
            obs = {Stall_IF, Stall_MW, Flush_DE, Flush_MW, For_A, For_B, mem_timeout};
            vectors++;
            if (obs !== expv[i]) begin
                $display("FAIL branch_stall[%0d]: got %b expected %b", i, obs, expv[i]);
                miscompares++;
            end
            @(posedge clk); #1;
        end
    endtask

    // Trap in 2nd MEM_WAIT cycle, trap during FLUSH ignored, trap beating a
    // fresh pending access in RUN, then an unstalled branch.
    task automatic test_trap();
        logic [6:0] obs;
        logic [5:0] stim [11] = '{6'b100000, 6'b100000, 6'b100010, 6'b100010,
                                  6'b000000, 6'b000000, 6'b100010, 6'b000000,
                                  6'b000000, 6'b000100, 6'b000000};
        logic [6:0] expv [11] = '{7'b1100000, 7'b1100000, 7'b0011000, 7'b0011000,
                                  7'b0000000, 7'b0000000, 7'b0011000, 7'b0011000,
                                  7'b0000000, 7'b0010000, 7'b0000000};
        {reg_wrMW, rd_MW, rs1_DE, rs2_DE} = '0;
        for (int i = 0; i < 11; i++) begin
            {mem_rdMW, mem_wrMW, dmem_ready, br_taken, trap_taken, rst} = stim[i];
            #1;
            obs = {Stall_IF, Stall_MW, Flush_DE, Flush_MW, For_A, For_B, mem_timeout};
            vectors++;
            if (obs !== expv[i]) begin
                $display("FAIL trap[%0d]: got %b expected %b", i, obs, expv[i]);
                miscompares++;
            end
            @(posedge clk); #1;
        end
    endtask

    // Zero-wait access, a 1-wait access, then a second access that must get
    // a fresh full wait window before timing out.
    task automatic test_back_to_back();
        logic [6:0] obs;
        logic [5:0] stim [10] = '{6'b101000, 6'b100000, 6'b101000, 6'b100000,
                                  6'b100000, 6'b100000, 6'b100000, 6'b100000,
                                  6'b100000, 6'b000000};
        logic [6:0] expv [10] = '{7'b0000000, 7'b1100000, 7'b0000000, 7'b1100000,
                                  7'b1100000, 7'b1100000, 7'b1100000, 7'b1100000,
                                  7'b0011001, 7'b0000000};
        {reg_wrMW, rd_MW, rs1_DE, rs2_DE} = '0;
        for (int i = 0; i < 10; i++) begin
            {mem_rdMW, mem_wrMW, dmem_ready, br_taken, trap_taken, rst} = stim[i];
            #1;
            obs = {Stall_IF, Stall_MW, Flush_DE, Flush_MW, For_A, For_B, mem_timeout};
            vectors++;
            if (obs !== expv[i]) begin
                $display("FAIL back_to_back[%0d]: got %b expected %b", i, obs, expv[i]);
                miscompares++;
            end
            @(posedge clk); #1;
        end
    endtask

    // Reset mid-wait: afterwards the controller sits idle in RUN with no
    // late flush or timeout pulse from the abandoned access.
    task automatic test_reset_midwait();
        logic [6:0] obs;
        logic [5:0] stim [9] = '{6'b100000, 6'b100000, 6'b100001, 6'b000000,
                                 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                 6'b000000};
        logic [6:0] expv [9] = '{7'b1100000, 7'b1100000, 7'b1100000, 7'b0000000,
                                 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000,
                                 7'b0000000};
        {reg_wrMW, rd_MW, rs1_DE, rs2_DE} = '0;
        for (int i = 0; i < 9; i++) begin
            {mem_rdMW, mem_wrMW, dmem_ready, br_taken, trap_taken, rst} = stim[i];
            #1;
            obs = {Stall_IF, Stall_MW, Flush_DE, Flush_MW, For_A, For_B, mem_timeout};
            vectors++;
            if (obs !== expv[i]) begin
                $display("FAIL reset_midwait[%0d]: got %b expected %b", i, obs, expv[i]);
                miscompares++;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_3cyc();
        test_timeout();
        test_branch_stall();
        test_trap();
        test_back_to_back();
        test_reset_midwait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush/forwarding controller for the 3-stage RV32I pipeline (IF → DE/EX → MW). It drives the `Stall_MW` hold of the MW pipeline register and the IF/DE hold and flush controls. It sequences multi-cycle data-memory accesses with a bounded wait, and issues flushes for taken branches, traps and memory timeouts. It also generates MW→DE operand-forwarding selects.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum MW wait cycles for `dmem_ready` before abandoning the access; legal range 1..255.
- `CNT_W`, default 8: wait-counter width; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rs1_DE`, `rs2_DE`  in  5 each  source registers of the instruction in DE/EX.
- `rd_MW`  in  5  destination register of the instruction in MW.
- `reg_wrMW`  in  1  MW instruction writes the register file.
- `mem_rdMW`, `mem_wrMW`  in  1 each  MW instruction is a load or a store.
- `dmem_ready`  in  1  data memory completes the MW access this cycle.
- `br_taken`  in  1  DE/EX resolved a taken branch or jump.
- `trap_taken`  in  1  CSR unit redirects to a trap or `mret` target this cycle.
- `Stall_IF`  out  1  hold the PC and the IF/DE register.
- `Stall_MW`  out  1  hold the MW pipeline register.
- `Flush_DE`  out  1  replace the IF/DE register contents with a NOP.
- `Flush_MW`  out  1  clear the MW register controls (reg_wr, csr_reg_wr, csr_reg_rd forced to 0).
- `For_A`, `For_B`  out  1 each  select the MW writeback value for operand A or B.
- `mem_timeout`  out  1  one-cycle pulse flagging an abandoned memory access.

## Operation
- FSM states: RUN, MEM_WAIT, FLUSH. State is registered.
- `mem_pend` = (`mem_rdMW` | `mem_wrMW`) & !`dmem_ready`.
- **RUN**
  - `trap_taken` → FLUSH.
  - else `mem_pend` → MEM_WAIT, with the wait counter set to 1.
  - else stay in RUN.
- **MEM_WAIT**
  - `trap_taken` → FLUSH.
  - else `dmem_ready` → RUN.
  - else if counter == MEM_TIMEOUT → FLUSH, with cause bit `to_q` set.
  - else counter increments.
- **FLUSH**
  - Lasts exactly one cycle, then → RUN; `to_q` and the counter are cleared.
  - `trap_taken` arriving during FLUSH is ignored.
- **Stalls (combinational)**
  - `Stall_IF` = `Stall_MW` = `mem_pend` & !`trap_taken` & state != FLUSH.
- **Flushes (combinational)**
  - In FLUSH: `Flush_DE` = `Flush_MW` = 1.
  - In RUN or MEM_WAIT: `trap_taken` asserts both flushes in the same cycle.
  - `br_taken` asserts `Flush_DE` only when no stall is active. A branch resolved under a stall is held in DE, so `br_taken` persists and the flush fires in the first unstalled cycle.
- **Priority:** `rst` > trap/timeout flush > memory stall > branch flush.
- `mem_timeout` = 1 only in a FLUSH cycle entered by timeout (`to_q`=1).
- **Forwarding:**
  - `For_A` = `reg_wrMW` & (`rd_MW` != 0) & (`rd_MW` == `rs1_DE`).
  - `For_B` is identical, using `rs2_DE`.
  - Both are masked to 0 while `Stall_MW` = 1, because load data is invalid until `dmem_ready`.

## Timing
- Reset values, state and outputs:
  - state = RUN, counter = 0, `to_q` = 0.
  - All outputs are 0 when inputs are idle; there are no registered outputs.
- `rst` asserted mid-access returns the FSM to RUN on the next edge and abandons any wait. No timeout is reported for that access.
- Stall latency is 0 cycles: a stall freezes the pipeline in the same cycle `mem_pend` rises. It releases in the cycle `dmem_ready` = 1; that cycle is not stalled, and the MW register advances at the following edge.
- Worst-case stall is MEM_TIMEOUT+1 cycles, followed by 1 FLUSH cycle.
- A zero-wait access (`dmem_ready`=1 in the first cycle) never leaves RUN.
- `trap_taken` together with `mem_pend`: the trap wins. Flushes assert with no stall, and the FSM goes → FLUSH.
- Back-to-back memory instructions each get an independent wait; the counter restarts at 1.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the `ctrl_state_e` enum (RUN, MEM_WAIT, FLUSH);
  - RV32 opcode constants `OP_LOAD` = 7'b0000011 and `OP_STORE` = 7'b0100011;
  - the register-index width constant.
- One natural sub-module, `forward_unit`, holds the purely combinational rs/rd compare and masking.
- The FSM, wait counter and flush logic stay in `pipe_hazard_ctrl`.

## Test plan
- **Load, 3-cycle memory.** Load in MW, `dmem_ready` low 3 cycles then high.
  - Required: `Stall_IF`/`Stall_MW` = 1 for exactly 3 cycles, 0 in the ready cycle.
  - Required: `For_A` = 0 while stalled, 1 in the ready cycle when rs1_DE = rd_MW = 5.
- **Timeout.** MEM_TIMEOUT = 4, `dmem_ready` never rises.
  - Required: stall for 5 cycles, then one cycle with `Flush_DE` = `Flush_MW` = `mem_timeout` = 1, then RUN with all outputs 0.
- **Branch under stall.** `br_taken` = 1 during a 2-cycle memory stall.
  - Required: `Flush_DE` = 0 while stalled, then 1 in the release cycle; `Flush_MW` = 0 throughout.
- **Trap during wait.** `trap_taken` pulses in the 2nd MEM_WAIT cycle.
  - Required: stalls drop that cycle, flushes assert that cycle and the next (FLUSH), and `mem_timeout` stays 0.
- **x0 and reset.** rd_MW = 0 with rs1_DE = 0 and `reg_wrMW` = 1 → `For_A` = 0. `rst` pulsed mid-MEM_WAIT → next cycle state RUN, counter 0, no flush or timeout pulse.
